// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter family.
// Direction encodings and a clamp helper used for load values and step sizes.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Clamp v to maxv (both treated as unsigned 32-bit quantities).
  function automatic logic [31:0] clamp_max(input logic [31:0] v, input logic [31:0] maxv);
    return (v > maxv) ? maxv : v;
  endfunction

endpackage

// File: rtl/udc_next_val.sv
// Next-count and wrap/saturate flag computation for the modulo up/down counter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
module udc_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s,
  input  logic             mode,
  input  logic             sat,
  output logic [WIDTH-1:0] next,
  output logic             ovf_n,
  output logic             udf_n
);

  // WIDTH+1 bits so that MOD = 2**WIDTH and the up-count carry are both representable.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MOD - 1);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, count} + {1'b0, s};

  always_comb begin
    next  = count;
    ovf_n = 1'b0;
    udf_n = 1'b0;
    if (mode == DIR_UP) begin
      if (sum > MAX_W) begin
        ovf_n = 1'b1;
        next  = sat ? MAX_W[WIDTH-1:0] : WIDTH'(sum - MOD_W);
      end else begin
        next = sum[WIDTH-1:0];
      end
    end else begin
      if (count >= s) begin
        next = count - s;
      end else begin
        udf_n = 1'b1;
        next  = sat ? '0 : WIDTH'({1'b0, count} + MOD_W - {1'b0, s});
      end
    end
  end

endmodule

// File: rtl/mod_up_down_counter.sv
// Parametrised modulo up/down counter with load, enable, tc and ovf/udf pulses (UDC_SAT_EN adds sat).
// Latency: count/ovf/udf registered, one cycle; tc combinational from count and mode.
// Backpressure: none; en simply holds the count.
module mod_up_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UDC_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [31:0]      MAX32 = 32'(MOD - 1);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH-1:0] nxt;
  logic             ovf_n;
  logic             udf_n;
  logic             sat_sel;

`ifdef UDC_SAT_EN
  assign sat_sel = sat;
`else
  assign sat_sel = 1'b0;
`endif

  assign s_eff    = WIDTH'(clamp_max(32'(step), MAX32));
  assign load_eff = WIDTH'(clamp_max(32'(load_val), MAX32));

  udc_next_val #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .count (count),
    .s     (s_eff),
    .mode  (mode),
    .sat   (sat_sel),
    .next  (nxt),
    .ovf_n (ovf_n),
    .udf_n (udf_n)
  );

  // Priority: rst > load > en > hold; flags only pulse on an enabled count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (load) begin
      count <= load_eff;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (en) begin
      count <= nxt;
      ovf   <= ovf_n;
      udf   <= udf_n;
    end else begin
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end
  end

  assign tc = (mode == DIR_UP) ? (count == MAX_V) : (count == '0);

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Directed and randomised checks of mod_up_down_counter at MOD=10 and MOD=16.
module tb_mod_up_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] step = 4'd0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       sat = 1'b0;
  logic [3:0] count10, count16;
  logic       tc10, tc16, ovf10, ovf16, udf10, udf16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_up_down_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
    .load(load), .load_val(load_val),
`ifdef UDC_SAT_EN
    .sat(sat),
`endif
    .count(count10), .tc(tc10), .ovf(ovf10), .udf(udf10)
  );

  mod_up_down_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
    .load(load), .load_val(load_val),
`ifdef UDC_SAT_EN
    .sat(sat),
`endif
    .count(count16), .tc(tc16), .ovf(ovf16), .udf(udf16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one clock edge.
  task automatic model(input int modv, input int c, output int nc, output bit o, output bit u);
    int s;
    int r;
    s  = (int'(step) > modv - 1) ? modv - 1 : int'(step);
    nc = c;
    o  = 1'b0;
    u  = 1'b0;
    if (rst) begin
      nc = 0;
    end else if (load) begin
      nc = (int'(load_val) > modv - 1) ? modv - 1 : int'(load_val);
    end else if (en) begin
      if (mode == 1'b0) begin
        r = c + s;
        if (r > modv - 1) begin
          o  = 1'b1;
          nc = sat ? modv - 1 : r - modv;
        end else begin
          nc = r;
        end
      end else begin
        if (c >= s) begin
          nc = c - s;
        end else begin
          u  = 1'b1;
          nc = sat ? 0 : c + modv - s;
        end
      end
    end
  endtask

  initial begin
    int exp_dn[4];
    int exp_uf[4];
    int m10, m16, n10, n16;
    bit o10, u10, o16, u16;
    exp_dn = '{7, 4, 1, 8};
    exp_uf = '{1, 0, 0, 1};

    // Reset state
    tick();
    check("rst_count", 32'(count10), 0);
    check("rst_ovf", 32'(ovf10), 0);
    check("rst_udf", 32'(udf10), 0);
    check("rst_tc_up", 32'(tc10), 0);

    // Up-count by 1 for 12 cycles
    rst = 1'b0; en = 1'b1; mode = 1'b0; step = 4'd1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("up_count", 32'(count10), 32'(i % 10));
      check("up_ovf", 32'(ovf10), (i == 10) ? 1 : 0);
      check("up_tc", 32'(tc10), ((i % 10) == 9) ? 1 : 0);
    end

    // Load 0, then count down by 3
    load = 1'b1; load_val = 4'd0; mode = 1'b1; step = 4'd3;
    tick();
    check("ld0_count", 32'(count10), 0);
    check("ld0_tc_down", 32'(tc10), 1);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dn_count", 32'(count10), 32'(exp_dn[i]));
      check("dn_udf", 32'(udf10), 32'(exp_uf[i]));
      check("dn_ovf", 32'(ovf10), 0);
      check("dn_tc", 32'(tc10), 0);
    end

    // Clamped load and clamped step
    load = 1'b1; load_val = 4'd15; mode = 1'b0;
    tick();
    check("ldclamp_count", 32'(count10), 9);
    check("ldclamp_ovf", 32'(ovf10), 0);
    check("ldclamp_udf", 32'(udf10), 0);
    check("ldclamp_tc", 32'(tc10), 1);
    load = 1'b0; step = 4'd12;
    tick();
    check("stepclamp_count", 32'(count10), 8);
    check("stepclamp_ovf", 32'(ovf10), 1);
    check("stepclamp_tc", 32'(tc10), 0);

`ifdef UDC_SAT_EN
    // Saturating up-count, then hold at the limit with repeated ovf
    sat = 1'b1; step = 4'd4;
    tick();
    check("sat1_count", 32'(count10), 9);
    check("sat1_ovf", 32'(ovf10), 1);
    tick();
    check("sat2_count", 32'(count10), 9);
    check("sat2_ovf", 32'(ovf10), 1);
    check("sat2_tc", 32'(tc10), 1);
    mode = 1'b1;
    #1;
    check("sat_tc_mode_flip", 32'(tc10), 0);
    load = 1'b1; load_val = 4'd1; step = 4'd3;
    tick();
    load = 1'b0;
    tick();
    check("satdn_count", 32'(count10), 0);
    check("satdn_udf", 32'(udf10), 1);
    sat = 1'b0;
`endif

    // Reset overrides load and enable
    load = 1'b1; load_val = 4'd5; mode = 1'b0; step = 4'd1;
    tick();
    check("ld5_count", 32'(count10), 5);
    rst = 1'b1; load_val = 4'd3; en = 1'b1;
    tick();
    check("rstld_count", 32'(count10), 0);
    check("rstld_ovf", 32'(ovf10), 0);
    check("rstld_udf", 32'(udf10), 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_count", 32'(count10), 0);
      check("hold_ovf", 32'(ovf10), 0);
    end

    // Large step wraps on both moduli
    load = 1'b1; load_val = 4'd2;
    tick();
    check("ld2_count16", 32'(count16), 2);
    load = 1'b0; en = 1'b1; mode = 1'b0; step = 4'd15;
    tick();
    check("m16_count", 32'(count16), 1);
    check("m16_ovf", 32'(ovf16), 1);
    check("m16_udf", 32'(udf16), 0);
    check("m10_count", 32'(count10), 1);
    check("m10_ovf", 32'(ovf10), 1);

    // Random sweep against the reference model
    rst = 1'b1;
    tick();
    m10 = 0; m16 = 0;
    for (int i = 0; i < 1000; i++) begin
      rst      = ($urandom_range(63) == 0);
      load     = ($urandom_range(7) == 0);
      en       = ($urandom_range(3) != 0);
      mode     = 1'($urandom_range(1));
      step     = 4'($urandom_range(15));
      load_val = 4'($urandom_range(15));
`ifdef UDC_SAT_EN
      sat      = 1'($urandom_range(1));
`endif
      model(10, m10, n10, o10, u10);
      model(16, m16, n16, o16, u16);
      tick();
      m10 = n10;
      m16 = n16;
      check("rnd10_count", 32'(count10), 32'(m10));
      check("rnd10_ovf", 32'(ovf10), 32'(o10));
      check("rnd10_udf", 32'(udf10), 32'(u10));
      check("rnd10_tc", 32'(tc10), (mode == 1'b0) ? 32'(m10 == 9) : 32'(m10 == 0));
      check("rnd16_count", 32'(count16), 32'(m16));
      check("rnd16_ovf", 32'(ovf16), 32'(o16));
      check("rnd16_udf", 32'(udf16), 32'(u16));
      check("rnd16_tc", 32'(tc16), (mode == 1'b0) ? 32'(m16 == 15) : 32'(m16 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_up_down_counter.md
# mod_up_down_counter

Parametrised modulo up/down counter, next generation of the team's fixed 4-bit up/down counter. Adds configurable width and modulus, programmable step, synchronous load, count enable, terminal-count indication and overflow/underflow event pulses, with optional saturating mode. Used standalone as a timebase/divider or as an address/index generator inside larger datapath blocks.

## Interface
- WIDTH, 4: counter width in bits.
- MOD, 10: modulus; count range is 0..MOD-1. Legal range 2..2**WIDTH.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  count enable; when 0, count holds.
- mode  in  1  direction: 0 = up, 1 = down.
- step  in  WIDTH  increment/decrement amount per enabled cycle.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- sat  in  1  saturate select (present only with UDC_SAT_EN).
- count  out  WIDTH  registered counter value.
- tc  out  1  terminal count, combinational from count and mode.
- ovf  out  1  registered one-cycle pulse: an up-count wrapped or saturated.
- udf  out  1  registered one-cycle pulse: a down-count wrapped or saturated.

## Operation
- Priority per clk edge: rst > load > en > hold.
- rst=1: count=0, ovf=0, udf=0.
- load=1: count = min(load_val, MOD-1); ovf=udf=0. en, mode and step ignored that cycle.
- Effective step s = min(step, MOD-1). s=0 holds count; no flags.
- Up (en=1, mode=0): compute count+s in WIDTH+1 bits. If result ≤ MOD-1, count=result. Otherwise count=result-MOD, ovf=1 (wrap).
- Down (en=1, mode=1): if count ≥ s, count=count-s. Otherwise count=count+MOD-s, udf=1 (wrap).
- With saturation active (sat=1): an up-count past MOD-1 gives count=MOD-1, ovf=1. A down-count below 0 gives count=0, udf=1. Already at the limit with en=1 and s>0: count holds and the flag pulses every such cycle.
- tc = (mode==0) ? (count==MOD-1) : (count==0). It follows mode changes immediately, with no clock needed.
- ovf and udf are 0 on every cycle without a qualifying event. They are never both 1.
- Mode may change on any cycle. The next enabled edge uses the new direction. There is no pipeline state to flush.
- MOD = 2**WIDTH: the wrap arithmetic reduces to natural WIDTH-bit rollover. The WIDTH+1 intermediate is still required for flag generation.

## Timing
- Latency: count, ovf and udf update on the clk edge where their inputs are sampled. One cycle from input to output.
- tc has zero-cycle combinational delay from count/mode.
- Reset asserted mid-count takes effect at the next edge and overrides load and en.
- All outputs are defined (0) from the first edge with rst=1. Before the first reset edge, outputs are undefined.

## Configuration
- UDC_SAT_EN defined: the sat port exists and saturating behaviour is selectable per cycle.
- UDC_SAT_EN undefined: no sat port; the counter always wraps. All other behaviour is identical.

## Structure
- Shared package counter_pkg holds:
  - direction constants DIR_UP=1'b0 and DIR_DOWN=1'b1;
  - a helper function clamping a value to MOD-1 (used for load_val and step).
- One sub-module, udc_next_val: purely combinational next-count and flag computation (count, s, mode, sat → next, ovf_n, udf_n).
- The top level holds the registers, the priority mux and tc.

## Test plan
- WIDTH=4, MOD=10. Apply rst, then en=1, mode=0, step=1 for 12 cycles. Required: count 0..9,0,1; ovf pulses exactly on the 9→0 edge; tc=1 while count=9.
- From count=0: mode=1, step=3, en=1. Required: 0→7 with udf=1, then 7→4→1→8 with udf=1 on the 1→8 edge; tc=1 only at count=0.
- load=1, load_val=15 with en=1. Required: count=9 (clamped), no flags. Next cycle step=12 (clamped to 9), up. Required: count=8, ovf=1.
- UDC_SAT_EN defined, sat=1, count=8, up, step=4. Required: count=9, ovf=1. Following cycle: count=9, ovf=1 again. Switch to mode=1: tc drops to 0 combinationally.
- Counting up at count=5, assert rst and load together. Required: count=0, ovf=udf=0 next edge. en=0 for 3 cycles: count holds at 0.
- WIDTH=4, MOD=16, up, step=15 from count=2. Required: count=1, ovf=1. Sweep random step/mode/load against a reference model for 1000 cycles.
